regfile_mp: RTL and testbench

Parametrised two-read/two-write register file for the pipelined datapath, replacing the fixed 16x16 register bank. It provides registered read ports, dual write ports with defined collision priority and a debug tap of one register. A hardware clear sequencer zeroes the array one entry per cycle. It sits between the decode stage (reads) and write-back (writes).

---
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two read ports, two write ports, tap and clear control.
// The master side (decode/write-back) drives addresses, write data and clr_req.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  logic              we1;
  logic              we2;
  logic [ADDR_W-1:0] wa1;
  logic [ADDR_W-1:0] wa2;
  logic [DATA_W-1:0] wd1;
  logic [DATA_W-1:0] wd2;

  logic [DATA_W-1:0] tap_data;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output rd_addr1, rd_addr2,
    output we1, we2, wa1, wa2, wd1, wd2,
    output clr_req,
    input  rd_data1, rd_data2, tap_data, clr_busy
  );

  modport slave (
    input  rd_addr1, rd_addr2,
    input  we1, we2, wa1, wa2, wd1, wd2,
    input  clr_req,
    output rd_data1, rd_data2, tap_data, clr_busy
  );

endinterface

// File: rtl/regfile_mp.sv
// Two-read/two-write register file with registered reads, tap port and a clear sequencer.
// Define RF_BYPASS_EN to forward same-cycle writes (and clear zeroing) to reads and tap.
module regfile_mp #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TAP_REG = 15
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_if.slave    bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TapAddr  = ADDR_W'(TAP_REG);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] tap_q, tap_d;

  // Clear sequencer: one entry zeroed per cycle, requests ignored while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Next array contents; port 2 is applied last so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == StClear) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (bus.we1) begin
        mem_d[bus.wa1] = bus.wd1;
      end
      if (bus.we2) begin
        mem_d[bus.wa2] = bus.wd2;
      end
    end
  end

  // With forwarding, reading the next-state array yields write data or the cleared zero.
  always_comb begin
`ifdef RF_BYPASS_EN
    rd1_d = mem_d[bus.rd_addr1];
    rd2_d = mem_d[bus.rd_addr2];
    tap_d = mem_d[TapAddr];
`else
    rd1_d = mem_q[bus.rd_addr1];
    rd2_d = mem_q[bus.rd_addr2];
    tap_d = mem_q[TapAddr];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
      tap_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      tap_q <= tap_d;
    end
  end

  assign bus.rd_data1 = rd1_q;
  assign bus.rd_data2 = rd2_q;
  assign bus.tap_data = tap_q;
  assign bus.clr_busy = (state_q == StClear);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for write/read/collision, plus
// hand-written sequences for bypass, clear and reset-during-clear.
module tb_regfile_mp;

`ifdef RF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_mp_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .TAP_REG(15)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we1;
    logic [3:0]  wa1;
    logic [15:0] wd1;
    logic        we2;
    logic [3:0]  wa2;
    logic [15:0] wd2;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic [15:0] exp_tap;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.we2 = 1'b0; bus.wa2 = '0; bus.wd2 = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic fill(input logic [15:0] val);
    for (int i = 0; i < 8; i++) begin
      bus.we1 = 1'b1; bus.wa1 = 4'(2 * i);     bus.wd1 = val;
      bus.we2 = 1'b1; bus.wa2 = 4'(2 * i + 1); bus.wd2 = val;
      tick();
    end
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr1 = 4'(i);
      bus.rd_addr2 = 4'(15 - i);
      tick();
      check({name, "_rd1"}, bus.rd_data1, 16'h0000);
      check({name, "_rd2"}, bus.rd_data2, 16'h0000);
    end
    check({name, "_tap"}, bus.tap_data, 16'h0000);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    idle_inputs();

    //                we1 wa1  wd1       we2 wa2  wd2       ra1 ra2 exp1      exp2      exp_tap
    vecs[0] = '{1'b1, 4'd3, 16'h1234, 1'b1, 4'd7, 16'hABCD, 4'd0, 4'd1, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd7, 16'h1234, 16'hABCD, 16'h0000};
    vecs[2] = '{1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, 4'd7, 4'd3, 16'hABCD, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'h2222, 16'h2222, 16'h0000};
    vecs[4] = '{1'b1, 4'd15, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd0, 16'h1234, 16'h0000,
                Byp ? 16'hBEEF : 16'h0000};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd1, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[6] = '{1'b1, 4'd0, 16'h0A0A, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd5, 16'hBEEF, 16'h2222, 16'hBEEF};
    vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd1, 16'h0A0A, 16'h0000, 16'hBEEF};

    rst = 1'b0;
    #22;
    rst = 1'b1;
    #1;
    check("reset_busy", {15'd0, bus.clr_busy}, 16'h0000);
    read_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      bus.we1 = vecs[i].we1; bus.wa1 = vecs[i].wa1; bus.wd1 = vecs[i].wd1;
      bus.we2 = vecs[i].we2; bus.wa2 = vecs[i].wa2; bus.wd2 = vecs[i].wd2;
      bus.rd_addr1 = vecs[i].ra1; bus.rd_addr2 = vecs[i].ra2;
      tick();
      check($sformatf("vec%0d_rd1", i), bus.rd_data1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), bus.rd_data2, vecs[i].exp2);
      check($sformatf("vec%0d_tap", i), bus.tap_data, vecs[i].exp_tap);
      check($sformatf("vec%0d_busy", i), {15'd0, bus.clr_busy}, 16'h0000);
    end
    idle_inputs();

    // Same-edge write and read of register 15 (old value BEEF).
    bus.we1 = 1'b1; bus.wa1 = 4'd15; bus.wd1 = 16'h00FF;
    bus.rd_addr1 = 4'd15;
    tick();
    bus.we1 = 1'b0;
    check("bypass_rd1_first", bus.rd_data1, Byp ? 16'h00FF : 16'hBEEF);
    check("bypass_tap_first", bus.tap_data, Byp ? 16'h00FF : 16'hBEEF);
    tick();
    check("bypass_rd1_second", bus.rd_data1, 16'h00FF);
    check("bypass_tap_second", bus.tap_data, 16'h00FF);

    // Full clear with a dropped write, a live read and an ignored second request.
    fill(16'hFFFF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    check("clear_busy_start", {15'd0, bus.clr_busy}, 16'h0001);
    n = 0;
    while (bus.clr_busy && n < 40) begin
      bus.we1     = (n == 10);
      bus.wa1     = 4'd2;
      bus.wd1     = 16'h1234;
      bus.clr_req = (n == 6);
      bus.rd_addr1 = 4'd15;
      tick();
      if (n == 3) check("clear_live_read", bus.rd_data1, 16'hFFFF);
      n++;
    end
    idle_inputs();
    check("clear_cycles", 16'(n), 16'd16);
    read_all_zero("after_clear");
    check("after_clear_busy", {15'd0, bus.clr_busy}, 16'h0000);

    // Reset asserted partway through a clear.
    fill(16'hFFFF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("midclear_busy_before", {15'd0, bus.clr_busy}, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    check("midclear_busy_reset", {15'd0, bus.clr_busy}, 16'h0000);
    check("midclear_tap_reset", bus.tap_data, 16'h0000);
    #1;
    rst = 1'b1;
    read_all_zero("midclear");
    bus.we2 = 1'b1; bus.wa2 = 4'd9; bus.wd2 = 16'h5A5A;
    tick();
    bus.we2 = 1'b0;
    bus.rd_addr2 = 4'd9;
    tick();
    check("post_reset_write", bus.rd_data2, 16'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
